// File: rtl/dca_matrix_row_streamer_if.sv
// Bundles the three handshake groups of the row streamer: instruction in,
// memory read request/response, and the outgoing tensor-row stream.
// master = the streamer itself, slave = its environment (LSU memory + consumer).
interface dca_matrix_row_streamer_if #(
   parameter int MATRIX_SIZE_PARA = 8,
   parameter int BW_TENSOR_SCALAR = 32,
   parameter int BW_ADDR          = 32
);
   localparam int BW_TENSOR_ROW = MATRIX_SIZE_PARA * BW_TENSOR_SCALAR;
   localparam int BW_NUM_ROW    = $clog2(MATRIX_SIZE_PARA) + 1;

   logic                     inst_wvalid;
   logic                     inst_wready;
   logic [BW_ADDR-1:0]       inst_addr;
   logic [BW_ADDR-1:0]       inst_stride;
   logic [BW_NUM_ROW-1:0]    inst_num_row;

   logic                     mem_rrequest;
   logic                     mem_rready;
   logic [BW_ADDR-1:0]       mem_raddr;
   logic                     mem_rdvalid;
   logic [BW_TENSOR_ROW-1:0] mem_rdata;

   logic                     load_tensor_row_wvalid;
   logic                     load_tensor_row_wready;
   logic                     load_tensor_row_wlast;
   logic [BW_TENSOR_ROW-1:0] load_tensor_row_wdata;

   modport master (
      input  inst_wvalid, inst_addr, inst_stride, inst_num_row,
      output inst_wready,
      output mem_rrequest, mem_raddr,
      input  mem_rready, mem_rdvalid, mem_rdata,
      output load_tensor_row_wvalid, load_tensor_row_wlast, load_tensor_row_wdata,
      input  load_tensor_row_wready
   );

   modport slave (
      output inst_wvalid, inst_addr, inst_stride, inst_num_row,
      input  inst_wready,
      input  mem_rrequest, mem_raddr,
      output mem_rready, mem_rdvalid, mem_rdata,
      input  load_tensor_row_wvalid, load_tensor_row_wlast, load_tensor_row_wdata,
      output load_tensor_row_wready
   );
endinterface

// File: rtl/dca_matrix_row_streamer.sv
// Row streamer: accepts one load instruction (base, stride, row count), issues
// credit-limited row reads to memory, buffers responses in a small FIFO and
// emits them as a tensor-row stream with wlast on the final row.
module dca_matrix_row_streamer #(
   parameter int MATRIX_SIZE_PARA = 8,
   parameter int BW_TENSOR_SCALAR = 32,
   parameter int BW_ADDR          = 32,
   parameter int FIFO_DEPTH       = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic busy,
   dca_matrix_row_streamer_if.master bus
);
   localparam int BW_TENSOR_ROW = MATRIX_SIZE_PARA * BW_TENSOR_SCALAR;
   localparam int BW_NUM_ROW    = $clog2(MATRIX_SIZE_PARA) + 1;
   localparam int PTR_W         = $clog2(FIFO_DEPTH);
   localparam int CNT_W         = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                   state_r;
   logic [BW_ADDR-1:0]       addr_r;
   logic [BW_ADDR-1:0]       stride_r;
   logic [BW_NUM_ROW-1:0]    remain_r;      // requests still to issue
   logic [BW_NUM_ROW-1:0]    rsp_remain_r;  // responses still expected for this instruction
   logic [CNT_W-1:0]         outstanding_r;
   logic [CNT_W-1:0]         drop_cnt_r;
   logic [CNT_W-1:0]         fifo_cnt_r;
   logic [PTR_W-1:0]         wr_ptr_r;
   logic [PTR_W-1:0]         rd_ptr_r;
   logic [BW_TENSOR_ROW-1:0] fifo_data_r [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]    fifo_last_r;

   logic [CNT_W-1:0]         credit_s;
   logic [CNT_W-1:0]         drop_pend_s;
   logic [CNT_W-1:0]         drop_clear_s;
   logic [BW_NUM_ROW-1:0]    num_sat_s;
   logic                     inst_ready_s;
   logic                     inst_hs_s;
   logic                     rreq_s;
   logic                     req_hs_s;
   logic                     push_s;
   logic                     drop_s;
   logic                     wvalid_s;
   logic                     pop_s;
   logic                     head_last_s;
   logic                     rsp_last_s;

   // Handshake decode and credit accounting from the registered state.
   always_comb begin
      credit_s     = CNT_W'(FIFO_DEPTH) - fifo_cnt_r - outstanding_r;
      inst_ready_s = (state_r == ST_IDLE) && enable && (drop_cnt_r == {CNT_W{1'b0}});
      inst_hs_s    = bus.inst_wvalid && inst_ready_s;
      rreq_s       = (state_r == ST_ISSUE) && enable &&
                     (remain_r != {BW_NUM_ROW{1'b0}}) && (credit_s != {CNT_W{1'b0}});
      req_hs_s     = rreq_s && bus.mem_rready;
      drop_s       = bus.mem_rdvalid && (drop_cnt_r != {CNT_W{1'b0}});
      push_s       = bus.mem_rdvalid && (drop_cnt_r == {CNT_W{1'b0}});
      wvalid_s     = enable && (fifo_cnt_r != {CNT_W{1'b0}});
      pop_s        = wvalid_s && bus.load_tensor_row_wready;
      head_last_s  = fifo_last_r[rd_ptr_r];
      rsp_last_s   = (rsp_remain_r == BW_NUM_ROW'(1));
      // Over-long instructions are clipped to one full matrix.
      if (bus.inst_num_row > BW_NUM_ROW'(MATRIX_SIZE_PARA)) begin
         num_sat_s = BW_NUM_ROW'(MATRIX_SIZE_PARA);
      end else begin
         num_sat_s = bus.inst_num_row;
      end
      // On abort, every read still in flight must be swallowed when it returns;
      // a response arriving in the abort cycle itself is already accounted for.
      drop_pend_s = drop_cnt_r + outstanding_r;
      if (bus.mem_rdvalid && (drop_pend_s != {CNT_W{1'b0}})) begin
         drop_clear_s = drop_pend_s - CNT_W'(1);
      end else begin
         drop_clear_s = drop_pend_s;
      end
   end

   // Outputs are forced low while reset is asserted so the reset cycle is quiet.
   assign bus.inst_wready            = ~rst & inst_ready_s;
   assign bus.mem_rrequest           = ~rst & rreq_s;
   assign bus.mem_raddr              = rst ? {BW_ADDR{1'b0}} : addr_r;
   assign bus.load_tensor_row_wvalid = ~rst & wvalid_s;
   assign bus.load_tensor_row_wlast  = ~rst & wvalid_s & head_last_s;
   assign bus.load_tensor_row_wdata  = rst ? {BW_TENSOR_ROW{1'b0}} : fifo_data_r[rd_ptr_r];
   assign busy = ~rst & ((state_r != ST_IDLE) || (fifo_cnt_r != {CNT_W{1'b0}}) ||
                         (drop_cnt_r != {CNT_W{1'b0}}));

   // Control FSM, read/credit counters, drop tracking and the row FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         addr_r        <= {BW_ADDR{1'b0}};
         stride_r      <= {BW_ADDR{1'b0}};
         remain_r      <= {BW_NUM_ROW{1'b0}};
         rsp_remain_r  <= {BW_NUM_ROW{1'b0}};
         outstanding_r <= {CNT_W{1'b0}};
         drop_cnt_r    <= {CNT_W{1'b0}};
         fifo_cnt_r    <= {CNT_W{1'b0}};
         wr_ptr_r      <= {PTR_W{1'b0}};
         rd_ptr_r      <= {PTR_W{1'b0}};
         fifo_last_r   <= {FIFO_DEPTH{1'b0}};
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data_r[i] <= {BW_TENSOR_ROW{1'b0}};
         end
      end else if (clear) begin
         state_r       <= ST_IDLE;
         remain_r      <= {BW_NUM_ROW{1'b0}};
         rsp_remain_r  <= {BW_NUM_ROW{1'b0}};
         outstanding_r <= {CNT_W{1'b0}};
         drop_cnt_r    <= drop_clear_s;
         fifo_cnt_r    <= {CNT_W{1'b0}};
         wr_ptr_r      <= {PTR_W{1'b0}};
         rd_ptr_r      <= {PTR_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (inst_hs_s && (num_sat_s != {BW_NUM_ROW{1'b0}})) begin
                  addr_r   <= bus.inst_addr;
                  stride_r <= bus.inst_stride;
                  remain_r <= num_sat_s;
                  state_r  <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (req_hs_s) begin
                  addr_r   <= addr_r + stride_r;
                  remain_r <= remain_r - BW_NUM_ROW'(1);
                  if (remain_r == BW_NUM_ROW'(1)) begin
                     state_r <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (pop_s && head_last_s) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase

         // Responses return in request order, so the last one of the
         // instruction is recognised by counting responses down.
         if (inst_hs_s && (state_r == ST_IDLE)) begin
            rsp_remain_r <= num_sat_s;
         end else if (push_s && (rsp_remain_r != {BW_NUM_ROW{1'b0}})) begin
            rsp_remain_r <= rsp_remain_r - BW_NUM_ROW'(1);
         end

         outstanding_r <= outstanding_r + CNT_W'(req_hs_s) - CNT_W'(push_s);
         fifo_cnt_r    <= fifo_cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);

         if (drop_s) begin
            drop_cnt_r <= drop_cnt_r - CNT_W'(1);
         end

         if (push_s) begin
            fifo_data_r[wr_ptr_r] <= bus.mem_rdata;
            fifo_last_r[wr_ptr_r] <= rsp_last_s;
            wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
         end

         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
      end
   end
endmodule
